// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst reader.
// Provides the FSM state encoding, output-buffer sizing and counter-width helper.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int OBUF_DEPTH = 2;
    localparam int OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer between the FIFO read port and the valid/ready stream.
// Head entry drives m_data_o; a write and a pop in the same cycle leave the count unchanged.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  rd_clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic [OBUF_CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(OBUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OBUF_CNT_W-1:0] count_q;
    logic                  pop;

    always_comb begin
        m_valid_o = (count_q != '0);
        m_data_o  = mem_q[rd_ptr_q];
        count_o   = count_q;
        pop       = m_valid_o && m_ready_i;
    end

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en_i, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from a FIFO read port into a 2-entry buffer and streams them out.
// Optional starve timeout is enabled with `define FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int  DATA_WIDTH = 10,
    parameter int  DEPTH      = 16,
    parameter int  TIMEOUT    = 64,
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                  rd_clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      burst_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  fifo_empty_i,
    input  logic                  fifo_underflow_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic                  err_o,
    output logic                  timeout_o
);

    rd_state_t             state_q, state_d;
    logic [CNT_W-1:0]      remaining_q;
    logic                  inflight_q;
    logic                  zero_done_q;
    logic                  err_q;
    logic [OBUF_CNT_W-1:0] obuf_count;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  drain_done;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STARVE_W = $clog2(TIMEOUT + 1);
    logic [STARVE_W-1:0] starve_q;
    logic                timeout_q;
    logic                starved;
    logic                timeout_hit;
`endif

    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        pop        = m_valid_o && m_ready_i;
        // Words already owed to the buffer after this cycle's pop; a new read needs a free slot.
        occupancy  = 3'(obuf_count) + 3'(inflight_q) - 3'(pop);
        fifo_rd_en_o = !rst_i && (state_q == READ) && !fifo_empty_i &&
                       (remaining_q != '0) && (occupancy < 3'(OBUF_DEPTH));
`ifdef FIFO_RD_TIMEOUT_EN
        starved     = (state_q == READ) && fifo_empty_i && (remaining_q != '0);
        timeout_hit = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i && (burst_len_i != '0)) state_d = READ;
            end
            READ: begin
                if (fifo_rd_en_o && (remaining_q == CNT_W'(1))) begin
                    state_d = DRAIN;
                end
`ifdef FIFO_RD_TIMEOUT_EN
                else if (starved && (starve_q == STARVE_W'(TIMEOUT - 1))) begin
                    state_d     = DRAIN;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (!inflight_q && (obuf_count == '0) && !pop) begin
                    state_d    = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_o = (state_q != IDLE);
        done_o = !rst_i && (zero_done_q || drain_done);
        err_o  = err_q;
    end

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            zero_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= fifo_rd_en_o;
            zero_done_q <= (state_q == IDLE) && start_i && (burst_len_i == '0);
            err_q       <= err_q | fifo_underflow_i;
            if ((state_q == IDLE) && start_i) begin
                remaining_q <= burst_len_i;
            end else if (fifo_rd_en_o) begin
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

`ifdef FIFO_RD_TIMEOUT_EN
    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            starve_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            starve_q <= starved ? starve_q + 1'b1 : '0;
            if (timeout_hit) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .rd_clk_i (rd_clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (inflight_q),
        .wr_data_i(fifo_rdata_i),
        .m_valid_o(m_valid_o),
        .m_data_o (m_data_o),
        .m_ready_i(m_ready_i),
        .count_o  (obuf_count)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO, expected-word queue and per-cycle compare.
// Timeout scenario is selected by FIFO_RD_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int DW    = 10;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int TO    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] blen = '0;
    logic          busy, done, rd_en, empty, mvalid, err, tmo;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] mdata;
    logic          uflow = 1'b0;
    logic          mready = 1'b0;

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TO)
    ) dut (
        .rd_clk_i        (clk),
        .rst_i           (rst),
        .start_i         (start),
        .burst_len_i     (blen),
        .busy_o          (busy),
        .done_o          (done),
        .fifo_rd_en_o    (rd_en),
        .fifo_rdata_i    (rdata),
        .fifo_empty_i    (empty),
        .fifo_underflow_i(uflow),
        .m_valid_o       (mvalid),
        .m_data_o        (mdata),
        .m_ready_i       (mready),
        .err_o           (err),
        .timeout_o       (tmo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Behavioural FIFO: data appears the cycle after a read enable.
    logic [DW-1:0] fmem [0:255];
    int   fwr = 0;
    int   frd = 0;
    logic rd_en_s = 1'b0;
    logic flush_req = 1'b0;

    assign empty = (frd == fwr);

    always @(posedge clk) begin
        if (flush_req) frd <= fwr;
        else if (rd_en_s && (frd != fwr)) begin
            rdata <= fmem[frd];
            frd   <= frd + 1;
        end
    end

    task automatic fifo_write(input logic [DW-1:0] w);
        fmem[fwr] = w;
        fwr++;
    endtask

    // Model: the stream must equal the expected word list in order, the buffer never
    // holds more than two owed words, no read is issued while empty, stalls hold data.
    logic [DW-1:0] expq [$];
    int   total_rd = 0;
    int   total_acc = 0;
    int   last_acc_cyc = 0;
    int   outstanding = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        rd_en_s = rd_en;
        if (rst) begin
            expq.delete();
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(mvalid), 1);
                chk("hold_data", int'(mdata), int'(prev_data));
            end
            if (mvalid && mready) begin
                total_acc++;
                last_acc_cyc = cyc;
                outstanding--;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h with no word expected", mdata);
                end else begin
                    chk("stream_data", int'(mdata), int'(expq.pop_front()));
                end
            end
            if (rd_en) begin
                total_rd++;
                outstanding++;
                chk("rd_while_empty", int'(empty), 0);
                chk("buf_bound", int'(outstanding <= 2), 1);
            end
            prev_stall = mvalid && !mready;
            prev_data  = mdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic start_burst(input int len, output int sc);
        tick();
        start = 1'b1;
        blen  = CW'(len);
        sc    = cyc;
        tick();
        start = 1'b0;
        blen  = '0;
    endtask

    task automatic wait_done(input string name, input int budget, output int dc);
        dc = -1;
        for (int n = 0; n < budget; n++) begin
            sample();
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: done_o not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_m_valid"}, int'(mvalid), 0);
        chk({tag, "_m_data"}, int'(mdata), 0);
    endtask

    initial begin
        int sc, dc, brd, bacc;

        // Reset state
        tick();
        tick();
        sample();
        check_idle_outputs("rst");
        chk("rst_err", int'(err), 0);
        chk("rst_timeout", int'(tmo), 0);
        tick();
        rst = 1'b0;

        // Full-rate burst of 8
        for (int i = 1; i <= 8; i++) begin
            fifo_write(DW'(i));
            expq.push_back(DW'(i));
        end
        mready = 1'b1;
        brd = total_rd;
        bacc = total_acc;
        start_burst(8, sc);
        wait_done("t1_done", 40, dc);
        chk("t1_words", total_acc - bacc, 8);
        chk("t1_reads", total_rd - brd, 8);
        chk("t1_first_to_last", last_acc_cyc - sc, 10);
        chk("t1_done_latency", dc - last_acc_cyc, 1);
        sample();
        chk("t1_done_pulse", int'(done), 0);
        chk("t1_busy_after", int'(busy), 0);

        // Backpressure: two reads then stall; start while busy is ignored
        for (int i = 0; i < 5; i++) begin
            fifo_write(DW'(10'h011 + i));
            expq.push_back(DW'(10'h011 + i));
        end
        mready = 1'b0;
        brd = total_rd;
        bacc = total_acc;
        start_burst(5, sc);
        repeat (8) sample();
        tick();
        start = 1'b1;
        blen  = CW'(3);
        tick();
        start = 1'b0;
        blen  = '0;
        repeat (3) sample();
        chk("t2_stalled_reads", total_rd - brd, 2);
        chk("t2_valid", int'(mvalid), 1);
        chk("t2_head", int'(mdata), 10'h011);
        chk("t2_busy", int'(busy), 1);
        tick();
        mready = 1'b1;
        wait_done("t2_done", 40, dc);
        chk("t2_reads", total_rd - brd, 5);
        chk("t2_words", total_acc - bacc, 5);

        // Starvation: 3 of 6 words present, then refill
        for (int i = 0; i < 6; i++) expq.push_back(DW'(10'h021 + i));
        for (int i = 0; i < 3; i++) fifo_write(DW'(10'h021 + i));
        brd = total_rd;
        bacc = total_acc;
        start_burst(6, sc);
        repeat (10) sample();
        chk("t3_partial_reads", total_rd - brd, 3);
        chk("t3_partial_words", total_acc - bacc, 3);
        chk("t3_busy", int'(busy), 1);
        chk("t3_valid", int'(mvalid), 0);
        tick();
        for (int i = 3; i < 6; i++) fifo_write(DW'(10'h021 + i));
        wait_done("t3_done", 40, dc);
        chk("t3_reads", total_rd - brd, 6);
        chk("t3_words", total_acc - bacc, 6);
        chk("t3_err", int'(err), 0);

        // Zero-length burst
        brd = total_rd;
        start_burst(0, sc);
        sample();
        chk("t4_done", int'(done), 1);
        chk("t4_busy", int'(busy), 0);
        sample();
        chk("t4_done_pulse", int'(done), 0);
        chk("t4_reads", total_rd - brd, 0);

        // Reset mid-burst after two accepted words, then a 1-word burst
        for (int i = 0; i < 6; i++) begin
            fifo_write(DW'(10'h031 + i));
            expq.push_back(DW'(10'h031 + i));
        end
        bacc = total_acc;
        start_burst(6, sc);
        for (int n = 0; n < 20; n++) begin
            if (total_acc - bacc >= 2) break;
            sample();
        end
        chk("t5_two_words", total_acc - bacc, 2);
        tick();
        rst = 1'b1;
        flush_req = 1'b1;
        tick();
        rst = 1'b0;
        flush_req = 1'b0;
        sample();
        check_idle_outputs("t5_after_rst");
        fifo_write(10'h03a);
        expq.push_back(10'h03a);
        brd = total_rd;
        bacc = total_acc;
        start_burst(1, sc);
        wait_done("t5_done", 20, dc);
        chk("t5_reads", total_rd - brd, 1);
        chk("t5_words", total_acc - bacc, 1);
        chk("t5_queue_empty", int'(expq.size()), 0);

`ifdef FIFO_RD_TIMEOUT_EN
        // Empty FIFO: four starved READ cycles force DRAIN, done next cycle
        brd = total_rd;
        start_burst(3, sc);
        wait_done("t6_done", 20, dc);
        chk("t6_done_cycle", dc - sc, 5);
        chk("t6_timeout", int'(tmo), 1);
        chk("t6_reads", total_rd - brd, 0);
        sample();
        chk("t6_timeout_sticky", int'(tmo), 1);
        chk("t6_busy", int'(busy), 0);
`else
        // Empty FIFO: READ waits indefinitely, timeout_o stays 0
        brd = total_rd;
        bacc = total_acc;
        start_burst(3, sc);
        repeat (10) sample();
        chk("t6_waiting_busy", int'(busy), 1);
        chk("t6_waiting_reads", total_rd - brd, 0);
        chk("t6_timeout_off", int'(tmo), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            fifo_write(DW'(10'h041 + i));
            expq.push_back(DW'(10'h041 + i));
        end
        wait_done("t6_done", 20, dc);
        chk("t6_words", total_acc - bacc, 3);
        chk("t6_timeout_after", int'(tmo), 0);
`endif

        // Sticky underflow error, cleared only by reset
        tick();
        uflow = 1'b1;
        tick();
        uflow = 1'b0;
        sample();
        chk("t7_err_set", int'(err), 1);
        repeat (3) sample();
        chk("t7_err_sticky", int'(err), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        chk("t7_err_cleared", int'(err), 0);
        chk("t7_timeout_cleared", int'(tmo), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within 50000 ns");
        $fatal(1);
    end

endmodule
